// File: rtl/dekatron_pkg.sv
// Shared types and constants for the dekatron stepper: FSM states, one-hot
// glow-position type and small helpers for position validity and BCD decode.
package dekatron_pkg;

   localparam int DEK_POSITIONS = 10;

   typedef logic [DEK_POSITIONS-1:0] dek_onehot_t;

   localparam dek_onehot_t POS_ZERO = 10'b0000000001;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PH_A   = 2'd1,
      PH_B   = 2'd2,
      SETTLE = 2'd3
   } dek_state_t;

   function automatic logic is_onehot(input dek_onehot_t v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < DEK_POSITIONS; i++) begin
         n = n + {3'b000, v[i]};
      end
      return (n == 4'd1);
   endfunction

   // Callers must range-check the digit first; 10..15 shift out to zero.
   function automatic dek_onehot_t bcd_decode(input logic [3:0] d);
      return POS_ZERO << d;
   endfunction

endpackage

// File: rtl/dekatron_phase_timer.sv
// Loadable 8-bit down-counter timing the guide phases and the settle window;
// done flags the last cycle of the loaded interval (count == 1).
module dekatron_phase_timer (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   output logic       o_done
);

   logic [7:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= 8'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != 8'd0) begin
         r_count <= r_count - 8'd1;
      end
   end

   assign o_done = (r_count == 8'd1);

endmodule

// File: rtl/dekatron_stepper.sv
// Dekatron glow stepper: two-phase guide pulse sequencer with a one-hot
// position register. Parallel preset port enabled by DEKATRON_STEPPER_LOAD_EN.
//
//   state  | meaning
//   IDLE   | Ready high, waiting for Request (or Load)
//   PH_A   | first guide pulse (Guide1 on inc, Guide2 on dec)
//   PH_B   | second guide pulse (the other guide)
//   SETTLE | glow has moved; dead time before next request
module dekatron_stepper
   import dekatron_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES  = 4,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Request,
   input  logic        Dec,
`ifdef DEKATRON_STEPPER_LOAD_EN
   input  logic        Load,
   input  logic [3:0]  LoadData,
`endif
   output logic        Ready,
   output logic        Guide1,
   output logic        Guide2,
   output logic [9:0]  Out,
   output logic        Zero,
   output logic        Carry
);

   localparam logic [7:0] P_VAL = 8'(PULSE_CYCLES);
   localparam logic [7:0] S_VAL = 8'(SETTLE_CYCLES);

   dek_state_t  r_state;
   dek_onehot_t r_out;
   logic        r_dec;
   logic        r_ready;
   logic        r_guide1;
   logic        r_guide2;
   logic        r_carry;

   logic        w_idle;
   logic        w_load_hit;
   logic        w_accept;
   logic        w_done;
   logic        w_timer_load;
   logic [7:0]  w_timer_val;
   dek_onehot_t w_next_out;
   logic        w_next_carry;

   assign w_idle = (r_state == IDLE);

`ifdef DEKATRON_STEPPER_LOAD_EN
   assign w_load_hit = w_idle && Load;
`else
   assign w_load_hit = 1'b0;
`endif

   assign w_accept = w_idle && Request && !w_load_hit;

   always_comb begin
      w_timer_load = 1'b0;
      w_timer_val  = 8'd0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_timer_load = 1'b1;
               w_timer_val  = P_VAL;
            end
         end
         PH_A: begin
            if (w_done) begin
               w_timer_load = 1'b1;
               w_timer_val  = P_VAL;
            end
         end
         PH_B: begin
            if (w_done) begin
               w_timer_load = 1'b1;
               w_timer_val  = S_VAL;
            end
         end
         default: begin
            w_timer_load = 1'b0;
            w_timer_val  = 8'd0;
         end
      endcase
   end

   dekatron_phase_timer u_timer (
      .i_clk      (Clk),
      .i_rst      (Rst),
      .i_load     (w_timer_load),
      .i_load_val (w_timer_val),
      .o_done     (w_done)
   );

   // A corrupted position recovers to digit 0 rather than propagating.
   always_comb begin
      w_next_out   = POS_ZERO;
      w_next_carry = 1'b0;
      if (is_onehot(r_out)) begin
         if (r_dec) begin
            w_next_out   = {r_out[0], r_out[9:1]};
            w_next_carry = r_out[0];
         end else begin
            w_next_out   = {r_out[8:0], r_out[9]};
            w_next_carry = r_out[9];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state  <= IDLE;
         r_out    <= POS_ZERO;
         r_dec    <= 1'b0;
         r_ready  <= 1'b1;
         r_guide1 <= 1'b0;
         r_guide2 <= 1'b0;
         r_carry  <= 1'b0;
      end else begin
         r_carry <= 1'b0;
         case (r_state)
            IDLE: begin
`ifdef DEKATRON_STEPPER_LOAD_EN
               if (w_load_hit) begin
                  if (LoadData <= 4'd9) begin
                     r_out <= bcd_decode(LoadData);
                  end
               end else
`endif
               if (w_accept) begin
                  r_state  <= PH_A;
                  r_dec    <= Dec;
                  r_ready  <= 1'b0;
                  r_guide1 <= !Dec;
                  r_guide2 <= Dec;
               end
            end
            PH_A: begin
               if (w_done) begin
                  r_state  <= PH_B;
                  r_guide1 <= r_dec;
                  r_guide2 <= !r_dec;
               end
            end
            PH_B: begin
               if (w_done) begin
                  r_state  <= SETTLE;
                  r_guide1 <= 1'b0;
                  r_guide2 <= 1'b0;
                  r_out    <= w_next_out;
                  r_carry  <= w_next_carry;
               end
            end
            SETTLE: begin
               if (w_done) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_ready  <= 1'b1;
               r_guide1 <= 1'b0;
               r_guide2 <= 1'b0;
            end
         endcase
      end
   end

   assign Ready  = r_ready;
   assign Guide1 = r_guide1;
   assign Guide2 = r_guide2;
   assign Out    = r_out;
   assign Zero   = r_out[0];
   assign Carry  = r_carry;

endmodule

// File: tb/tb_dekatron_stepper.sv
// Self-checking bench for dekatron_stepper; load tests are compiled only
// when DEKATRON_STEPPER_LOAD_EN is defined.
module tb_dekatron_stepper;

   localparam int P = 4;
   localparam int S = 2;

   logic       Clk;
   logic       Rst;
   logic       Request;
   logic       Dec;
`ifdef DEKATRON_STEPPER_LOAD_EN
   logic       Load;
   logic [3:0] LoadData;
`endif
   logic       Ready;
   logic       Guide1;
   logic       Guide2;
   logic [9:0] Out;
   logic       Zero;
   logic       Carry;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_pos  = 0;
   logic [10:0] exp_q[$];

   dekatron_stepper #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Request  (Request),
      .Dec      (Dec),
`ifdef DEKATRON_STEPPER_LOAD_EN
      .Load     (Load),
      .LoadData (LoadData),
`endif
      .Ready    (Ready),
      .Guide1   (Guide1),
      .Guide2   (Guide2),
      .Out      (Out),
      .Zero     (Zero),
      .Carry    (Carry)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [9:0] pos_to_onehot(input int p);
      logic [9:0] one;
      one = 10'd1;
      return one << p;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (Ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (Ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_ready: Ready=%b after %0d cycles, required 1", Ready, n);
      end
   endtask

   // One step with full per-cycle checks; expectation queued at acceptance.
   task automatic run_step(input logic dec, input logic chk_guides);
      logic [9:0] old_out;
      logic       exp_c;
      logic [1:0] exp_g;
      logic [10:0] e;
      wait_ready();
      old_out = pos_to_onehot(exp_pos);
      if (dec) begin
         exp_c   = (exp_pos == 0);
         exp_pos = (exp_pos == 0) ? 9 : exp_pos - 1;
      end else begin
         exp_c   = (exp_pos == 9);
         exp_pos = (exp_pos + 1) % 10;
      end
      exp_q.push_back({exp_c, pos_to_onehot(exp_pos)});
      Request = 1'b1;
      Dec     = dec;
      tick();
      Request = 1'b0;
      Dec     = 1'b0;
      for (int k = 1; k <= 2 * P; k++) begin
         if (k <= P) exp_g = dec ? 2'b01 : 2'b10;
         else        exp_g = dec ? 2'b10 : 2'b01;
         if (chk_guides) begin
            n_checks++;
            if ({Guide1, Guide2} !== exp_g) begin
               n_fail++;
               $display("FAIL guides cyc%0d: got %b%b, required %b", k, Guide1, Guide2, exp_g);
            end
         end
         n_checks++;
         if (Carry !== 1'b0 || Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL phase cyc%0d: Carry=%b Ready=%b, required 0 0", k, Carry, Ready);
         end
         if (k == 2 * P) begin
            n_checks++;
            if (Out !== old_out) begin
               n_fail++;
               $display("FAIL out_hold: got %h, required %h", Out, old_out);
            end
         end
         tick();
      end
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: queue empty at step completion");
      end else begin
         e = exp_q.pop_front();
         n_checks++;
         if (Out !== e[9:0] || Carry !== e[10]) begin
            n_fail++;
            $display("FAIL step_result: Out=%h Carry=%b, required %h %b", Out, Carry, e[9:0], e[10]);
         end
         n_checks++;
         if ({Guide1, Guide2, Ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL settle1: g1g2rdy=%b%b%b, required 000", Guide1, Guide2, Ready);
         end
      end
      for (int s = 1; s < S; s++) begin
         tick();
         n_checks++;
         if (Carry !== 1'b0 || Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL settle: Carry=%b Ready=%b, required 0 0", Carry, Ready);
         end
      end
      tick();
      n_checks++;
      if (Ready !== 1'b1 || Carry !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_return: Ready=%b Carry=%b, required 1 0", Ready, Carry);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      tick();
      tick();
      Rst = 1'b0;
      exp_pos = 0;
      n_checks++;
      if (Out !== 10'h001 || Zero !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_out: Out=%h Zero=%b, required 001 1", Out, Zero);
      end
      n_checks++;
      if ({Ready, Guide1, Guide2, Carry} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctl: rdy,g1,g2,c=%b%b%b%b, required 1000", Ready, Guide1, Guide2, Carry);
      end
   endtask

   task automatic test_increment();
      run_step(1'b0, 1'b1);
      n_checks++;
      if (Out !== 10'h002 || Zero !== 1'b0) begin
         n_fail++;
         $display("FAIL inc_out: Out=%h Zero=%b, required 002 0", Out, Zero);
      end
   endtask

   task automatic test_back_to_back();
      test_reset();
      for (int i = 0; i < 10; i++) run_step(1'b0, 1'b0);
      n_checks++;
      if (Out !== 10'h001 || Zero !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_out: Out=%h Zero=%b, required 001 1", Out, Zero);
      end
   endtask

   task automatic test_decrement();
      test_reset();
      run_step(1'b1, 1'b1);
      n_checks++;
      if (Out !== 10'h200) begin
         n_fail++;
         $display("FAIL dec_out: Out=%h, required 200", Out);
      end
      run_step(1'b1, 1'b0);
   endtask

   task automatic test_request_held();
      logic [9:0] prev;
      int steps;
      test_reset();
      steps = 0;
      prev  = Out;
      Request = 1'b1;
      for (int c = 0; c < 3 * (2 * P + S + 1); c++) begin
         tick();
         if (Out !== prev) steps++;
         prev = Out;
         n_checks++;
         if (Guide1 === 1'b1 && Guide2 === 1'b1) begin
            n_fail++;
            $display("FAIL guide_overlap: both guides high at cycle %0d", c);
         end
      end
      Request = 1'b0;
      exp_pos = 3;
      n_checks++;
      if (steps !== 3 || Out !== 10'h008) begin
         n_fail++;
         $display("FAIL held_req: steps=%0d Out=%h, required 3 008", steps, Out);
      end
      n_checks++;
      if (Ready !== 1'b1) begin
         n_fail++;
         $display("FAIL held_ready: Ready=%b, required 1", Ready);
      end
      tick();
   endtask

   task automatic test_reset_mid_phase();
      test_reset();
      run_step(1'b0, 1'b0);
      wait_ready();
      Request = 1'b1;
      tick();
      Request = 1'b0;
      repeat (P + 1) tick();
      n_checks++;
      if ({Guide1, Guide2} !== 2'b01) begin
         n_fail++;
         $display("FAIL in_ph_b: g1g2=%b%b, required 01", Guide1, Guide2);
      end
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      exp_pos = 0;
      n_checks++;
      if (Out !== 10'h001 || {Guide1, Guide2, Ready, Carry} !== 4'b0010) begin
         n_fail++;
         $display("FAIL mid_reset: Out=%h g1g2rdyc=%b%b%b%b, required 001 0010",
                  Out, Guide1, Guide2, Ready, Carry);
      end
      run_step(1'b0, 1'b0);
   endtask

`ifdef DEKATRON_STEPPER_LOAD_EN
   task automatic test_load();
      test_reset();
      Load = 1'b1;
      LoadData = 4'd7;
      tick();
      Load = 1'b0;
      exp_pos = 7;
      n_checks++;
      if (Out !== 10'h080 || {Guide1, Guide2, Carry, Ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL load7: Out=%h g1g2cr=%b%b%b%b, required 080 0001", Out, Guide1, Guide2, Carry, Ready);
      end
      Load = 1'b1;
      LoadData = 4'd12;
      tick();
      Load = 1'b0;
      n_checks++;
      if (Out !== 10'h080) begin
         n_fail++;
         $display("FAIL load12: Out=%h, required 080", Out);
      end
      Load = 1'b1;
      LoadData = 4'd3;
      Request = 1'b1;
      tick();
      Load = 1'b0;
      Request = 1'b0;
      exp_pos = 3;
      for (int k = 0; k < 2 * P + 2; k++) begin
         n_checks++;
         if (Guide1 !== 1'b0 || Guide2 !== 1'b0 || Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_prio: g1g2=%b%b Ready=%b, required 00 1", Guide1, Guide2, Ready);
         end
         tick();
      end
      n_checks++;
      if (Out !== 10'h008) begin
         n_fail++;
         $display("FAIL load3: Out=%h, required 008", Out);
      end
      run_step(1'b0, 1'b0);
   endtask
`endif

   initial begin
      Rst = 1'b0;
      Request = 1'b0;
      Dec = 1'b0;
`ifdef DEKATRON_STEPPER_LOAD_EN
      Load = 1'b0;
      LoadData = 4'd0;
`endif
      #1;
      test_reset();
      test_increment();
      test_back_to_back();
      test_decrement();
      test_request_held();
      test_reset_mid_phase();
`ifdef DEKATRON_STEPPER_LOAD_EN
      test_load();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
